// File: rtl/logic_reduce_elastic.sv
// rtl/logic_reduce_elastic.sv - handshaked per-packet AND/NAND/OR/NOR/XOR/XNOR reduction
// Results queue in a 2-entry buffer so the input side keeps streaming under short backpressure.

module logic_reduce_elastic_fifo #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic [1:0]    count
);

  logic [DW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;

  // Callers only push when count < 2 and only pop when count > 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

module logic_reduce_elastic #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16,
  localparam int CNT_W    = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] ins,
  input  logic [2:0]       ins_op,
  input  logic             ins_last,
  input  logic             ins_valid,
  output logic             ins_ready,
  output logic             outs,
  output logic [CNT_W-1:0] outs_beats,
  output logic             outs_valid,
  input  logic             outs_ready
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

  typedef enum logic [1:0] {
    FAM_AND,
    FAM_OR,
    FAM_XOR
  } fam_t;

  logic             in_pkt;
  logic [2:0]       op_q;
  logic             acc;
  logic [CNT_W-1:0] cnt;

  logic [2:0]       cur_op;
  fam_t             fam;
  logic             invert;
  logic             beat_r;
  logic             comb_val;
  logic             result;
  logic [CNT_W-1:0] cnt_next;

  logic             accept;
  logic             push;
  logic             pop;
  logic [CNT_W:0]   head;
  logic [1:0]       fifo_count;

  // The op is only honoured on the first beat; later beats use the latched copy.
  always_comb begin
    cur_op = in_pkt ? op_q : ins_op;

    case (cur_op)
      3'd0, 3'd1: fam = FAM_AND;
      3'd4, 3'd5: fam = FAM_XOR;
      default:    fam = FAM_OR;
    endcase

    invert = (cur_op == 3'd1) || (cur_op == 3'd3) || (cur_op == 3'd5);

    case (fam)
      FAM_AND: beat_r = &ins;
      FAM_XOR: beat_r = ^ins;
      default: beat_r = |ins;
    endcase

    comb_val = beat_r;
    if (in_pkt) begin
      case (fam)
        FAM_AND: comb_val = acc & beat_r;
        FAM_XOR: comb_val = acc ^ beat_r;
        default: comb_val = acc | beat_r;
      endcase
    end

    cnt_next = CNT_W'(1);
    if (in_pkt) begin
      cnt_next = (cnt == MAX_CNT) ? MAX_CNT : cnt + CNT_W'(1);
    end

    result = comb_val ^ invert;
  end

  assign ins_ready = rst & (fifo_count < 2'd2);
  assign accept    = ins_valid & ins_ready;
  assign push      = accept & ins_last;
  assign pop       = outs_valid & outs_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_pkt <= 1'b0;
      op_q   <= 3'd0;
      acc    <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      in_pkt <= ~ins_last;
      op_q   <= cur_op;
      acc    <= comb_val;
      cnt    <= cnt_next;
    end
  end

  logic_reduce_elastic_fifo #(
    .DW(CNT_W + 1)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data({result, cnt_next}),
    .pop      (pop),
    .head     (head),
    .count    (fifo_count)
  );

  assign outs       = head[CNT_W];
  assign outs_beats = head[CNT_W-1:0];
  assign outs_valid = (fifo_count != 2'd0);

endmodule
